// File: rtl/load_store_unit_if.sv
// Request/response channel and data-memory port of load_store_unit.
// slave is the unit itself; master is the core together with the data memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_write_en, mem_data_in
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_write_en, mem_data_in
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle byte/halfword/word load-store initiator for a word-wide data memory.
// Optional LSU_ALIGN_CHECK_EN: reject misaligned halfword/word accesses instead of ignoring low address bits.
module load_store_unit #(
    parameter int DMEM_BITS = 10
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;

    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic [31:0] r_mem_addr;
    logic        r_mem_write_en;
    logic [31:0] r_mem_data_in;

    logic [29:0] w_word_idx;
    logic        w_range_err;
    logic        w_size_err;
    logic        w_misalign;
    logic        w_req_err;
    logic        w_needs_read;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_word_idx  = bus.req_addr[31:2];
    assign w_range_err = (w_word_idx >> DMEM_BITS) != 30'd0;
    assign w_size_err  = bus.req_size == SZ_BAD;

`ifdef LSU_ALIGN_CHECK_EN
    assign w_misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                        ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req_err    = w_range_err || w_size_err || w_misalign;
    // Sub-word stores need the old word for read-modify-write.
    assign w_needs_read = !bus.req_we || (bus.req_size != SZ_WORD);

    // Lane extraction and extension of the word captured during READ.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_byte      = bus.mem_data_out[{r_lane, 3'b000} +: 8];
        w_half      = bus.mem_data_out[{r_lane[1], 4'b0000} +: 16];
        w_load_data = bus.mem_data_out;
        case (r_size)
            SZ_BYTE: w_load_data = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
            SZ_HALF: w_load_data = {{16{w_half[15] & ~r_unsigned}}, w_half};
            default: w_load_data = bus.mem_data_out;
        endcase
    end

    always_comb begin
        w_merged = bus.mem_data_out;
        case (r_size)
            SZ_BYTE: w_merged[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
            SZ_HALF: w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merged = r_wdata;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_we           <= 1'b0;
            r_size         <= SZ_BYTE;
            r_unsigned     <= 1'b0;
            r_lane         <= 2'b00;
            r_wdata        <= 32'd0;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= 32'd0;
            r_resp_err     <= 1'b0;
            r_mem_addr     <= 32'd0;
            r_mem_write_en <= 1'b0;
            r_mem_data_in  <= 32'd0;
        end else begin
            r_mem_write_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we        <= bus.req_we;
                        r_size      <= bus.req_size;
                        r_unsigned  <= bus.req_unsigned;
                        r_lane      <= bus.req_addr[1:0];
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'd0;
                            r_state      <= S_RESP;
                        end else if (w_needs_read) begin
                            r_mem_addr <= {2'b00, w_word_idx};
                            r_state    <= S_READ;
                        end else begin
                            r_mem_addr     <= {2'b00, w_word_idx};
                            r_mem_data_in  <= bus.req_wdata;
                            r_mem_write_en <= 1'b1;
                            r_state        <= S_WRITE;
                        end
                    end
                end

                S_READ: begin
                    if (r_we) begin
                        r_mem_data_in  <= w_merged;
                        r_mem_write_en <= 1'b1;
                        r_state        <= S_WRITE;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load_data;
                        r_state      <= S_RESP;
                    end
                end

                S_WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'd0;
                    r_state      <= S_RESP;
                end

                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_rdata   = r_resp_rdata;
    assign bus.resp_err     = r_resp_err;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_write_en = r_mem_write_en;
    assign bus.mem_data_in  = r_mem_data_in;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a word-array reference model predicts every
// response, write and latency; directed tests pin the model with literal values.
module tb_load_store_unit;
    localparam int DMEM_BITS = 10;
    localparam int DEPTH     = 1 << DMEM_BITS;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if lsu_bus();

    load_store_unit #(.DMEM_BITS(DMEM_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (lsu_bus)
    );

    // Data memory seen by the DUT, and the model's own copy of it.
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    assign lsu_bus.mem_data_out = mem[lsu_bus.mem_addr[DMEM_BITS-1:0]];
    always @(posedge clk)
        if (lsu_bus.mem_write_en) mem[lsu_bus.mem_addr[DMEM_BITS-1:0]] <= lsu_bus.mem_data_in;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int          cyc = 0;
    int          acc_cyc = 0;
    bit          busy = 1'b0;
    bit          prev_valid = 1'b0;
    int          n_writes = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    int          last_lat = 0;
    int          last_valid_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one request, from byte-lane arithmetic on the model memory.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [29:0] widx;
        int          lane, nbits, shift;
        logic [31:0] mask, word, val;
        e = '{rdata: 32'd0, err: 1'b0, lat: 0, wr: 1'b0, waddr: 32'd0, wdata: 32'd0};
        widx  = addr[31:2];
        lane  = int'(addr % 4);
        e.err = (widx >= 30'(DEPTH)) || (size == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
        if ((size == 2'b01 && (addr % 2) != 0) || (size == 2'b10 && (addr % 4) != 0)) e.err = 1'b1;
`endif
        if (e.err) begin
            e.lat = 1;
            return e;
        end
        word  = ref_mem[widx[DMEM_BITS-1:0]];
        nbits = (size == 2'b00) ? 8 : (size == 2'b01) ? 16 : 32;
        shift = (size == 2'b00) ? 8 * lane : (size == 2'b01) ? 16 * (lane / 2) : 0;
        mask  = (nbits == 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
        if (!we) begin
            val = (word >> shift) & mask;
            if (!uns && nbits < 32 && ((val >> (nbits - 1)) & 32'd1) != 0) val = val | ~mask;
            e.lat   = 2;
            e.rdata = val;
        end else begin
            e.lat   = (nbits == 32) ? 2 : 3;
            e.wr    = 1'b1;
            e.waddr = {2'b00, addr[31:2]};
            e.wdata = (word & ~(mask << shift)) | ((wdata & mask) << shift);
        end
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Compare process: every cycle, outputs against the model's queued expectations.
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (reset) begin
            busy = 1'b0;
            prev_valid = 1'b0;
            exp_q.delete();
            wr_q.delete();
        end else begin
            check("req_ready", 32'(lsu_bus.req_ready), 32'(!busy));
            if (lsu_bus.mem_write_en) begin
                if (wr_q.size() == 0) begin
                    check("spurious_write_en", 32'(lsu_bus.mem_write_en), 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", lsu_bus.mem_addr, w.addr);
                    check("wr_data", lsu_bus.mem_data_in, w.data);
                    ref_mem[w.addr[DMEM_BITS-1:0]] = w.data;
                    n_writes++;
                    last_waddr = lsu_bus.mem_addr;
                    last_wdata = lsu_bus.mem_data_in;
                end
            end
            if (lsu_bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_resp_valid", 32'(lsu_bus.resp_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    if (!prev_valid) begin
                        last_lat = cyc - acc_cyc;
                        check("latency", 32'(last_lat), 32'(e.lat));
                        check("write_done_before_resp", 32'(wr_q.size()), 32'd0);
                    end
                    check("resp_rdata", lsu_bus.resp_rdata, e.rdata);
                    check("resp_err", 32'(lsu_bus.resp_err), 32'(e.err));
                    if (lsu_bus.resp_ready) begin
                        last_rdata = lsu_bus.resp_rdata;
                        last_err   = lsu_bus.resp_err;
                        void'(exp_q.pop_front());
                        busy = 1'b0;
                    end
                end
            end
            prev_valid = lsu_bus.resp_valid && !lsu_bus.resp_ready;
            if (lsu_bus.req_valid && lsu_bus.req_ready) begin
                busy    = 1'b1;
                acc_cyc = cyc;
            end
        end
    end

    task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        lsu_bus.req_valid    = 1'b1;
        lsu_bus.req_we       = we;
        lsu_bus.req_size     = size;
        lsu_bus.req_unsigned = uns;
        lsu_bus.req_addr     = addr;
        lsu_bus.req_wdata    = wdata;
    endtask

    task automatic expect_req(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        wr_t  w;
        e = model(we, size, uns, addr, wdata);
        exp_q.push_back(e);
        if (e.wr) begin
            w.addr = e.waddr;
            w.data = e.wdata;
            wr_q.push_back(w);
        end
    endtask

    // One full transaction; resp_ready stays low for the first 'stall' response cycles.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        bit ok;
        int n, vcnt;
        expect_req(we, size, uns, addr, wdata);
        set_req(we, size, uns, addr, wdata);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = lsu_bus.req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        lsu_bus.req_valid = 1'b0;
        check("accept_in_time", 32'(ok), 32'd1);
        lsu_bus.resp_ready = (stall == 0);
        ok   = 1'b0;
        n    = 0;
        vcnt = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (lsu_bus.resp_valid) vcnt++;
            ok = lsu_bus.resp_valid && lsu_bus.resp_ready;
            @(posedge clk);
            #1;
            n++;
            if (vcnt >= stall) lsu_bus.resp_ready = 1'b1;
        end
        lsu_bus.resp_ready = 1'b0;
        check("resp_in_time", 32'(ok), 32'd1);
        last_valid_cycles = vcnt;
    endtask

    // Byte store aborted by reset while the unit is in READ.
    task automatic reset_during_read(input logic [31:0] addr, input logic [31:0] wdata);
        expect_req(1'b1, 2'b00, 1'b0, addr, wdata);
        set_req(1'b1, 2'b00, 1'b0, addr, wdata);
        @(posedge clk);
        #1;
        lsu_bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(lsu_bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(lsu_bus.resp_valid), 32'd0);
        check("rst_write_en", 32'(lsu_bus.mem_write_en), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_before;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'(i) * 32'h9E37_79B9;
            ref_mem[i] = 32'(i) * 32'h9E37_79B9;
        end
        lsu_bus.req_valid    = 1'b0;
        lsu_bus.req_we       = 1'b0;
        lsu_bus.req_size     = 2'b00;
        lsu_bus.req_unsigned = 1'b0;
        lsu_bus.req_addr     = 32'd0;
        lsu_bus.req_wdata    = 32'd0;
        lsu_bus.resp_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(lsu_bus.req_ready), 32'd1);
        check("reset_resp_valid", 32'(lsu_bus.resp_valid), 32'd0);
        check("reset_resp_rdata", lsu_bus.resp_rdata, 32'd0);
        check("reset_resp_err", 32'(lsu_bus.resp_err), 32'd0);
        check("reset_write_en", 32'(lsu_bus.mem_write_en), 32'd0);
        check("reset_mem_addr", lsu_bus.mem_addr, 32'd0);
        check("reset_mem_data_in", lsu_bus.mem_data_in, 32'd0);
        @(posedge clk);
        #1;

        // Word store then word load.
        wr_before = n_writes;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
        check("ws_write_count", 32'(n_writes - wr_before), 32'd1);
        check("ws_mem_addr", last_waddr, 32'd4);
        check("ws_latency", 32'(last_lat), 32'd2);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0);
        check("wl_rdata", last_rdata, 32'hDEAD_BEEF);
        check("wl_latency", 32'(last_lat), 32'd2);

        // Byte loads, signed and unsigned.
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'd0, 0);
        check("lb_signed", last_rdata, 32'hFFFF_FFBE);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'd0, 0);
        check("lb_unsigned", last_rdata, 32'h0000_00BE);

        // Byte store read-modify-write.
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0055, 0);
        check("sb_merged", last_wdata, 32'hDE55_BEEF);
        check("sb_latency", 32'(last_lat), 32'd3);
        check("sb_rdata_zero", last_rdata, 32'd0);

        // Halfword at an odd address.
        wr_before = n_writes;
        do_req(1'b0, 2'b01, 1'b0, 32'h13, 32'd0, 0);
`ifdef LSU_ALIGN_CHECK_EN
        check("lh_misalign_err", 32'(last_err), 32'd1);
        check("lh_misalign_latency", 32'(last_lat), 32'd1);
        check("lh_misalign_no_write", 32'(n_writes - wr_before), 32'd0);
`else
        check("lh_upper_rdata", last_rdata, 32'hFFFF_DE55);
        check("lh_upper_err", 32'(last_err), 32'd0);
`endif

        // Range and size errors.
        wr_before = n_writes;
        do_req(1'b1, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h1234_5678, 0);
        check("range_err", 32'(last_err), 32'd1);
        check("range_latency", 32'(last_lat), 32'd1);
        do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'd0, 0);
        check("size11_err", 32'(last_err), 32'd1);
        check("size11_latency", 32'(last_lat), 32'd1);
        check("err_no_write", 32'(n_writes - wr_before), 32'd0);

        // Reset in READ of a byte store leaves memory untouched.
        wr_before = n_writes;
        reset_during_read(32'h10, 32'h0000_00AA);
        check("abort_no_write", 32'(n_writes - wr_before), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0);
        check("abort_mem_intact", last_rdata, 32'hDE55_BEEF);

        // Response held for 5 cycles of resp_ready low.
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 5);
        check("stall_rdata", last_rdata, 32'h0000_BEEF);
        check("stall_valid_cycles", 32'(last_valid_cycles), 32'd6);

        // Further vectors: halfword store/loads, top-of-memory word, every byte lane, misaligned word.
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF_8001, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h16, 32'd0, 0);
        check("sh_lh_signed", last_rdata, 32'hFFFF_8001);
        do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'd0, 0);
        check("sh_lh_unsigned", last_rdata, 32'h0000_8001);
        do_req(1'b1, 2'b10, 1'b0, 32'(4 * DEPTH - 4), 32'h0BAD_F00D, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'(4 * DEPTH - 4), 32'd0, 0);
        check("top_word", last_rdata, 32'h0BAD_F00D);
        for (int k = 0; k < 4; k++) do_req(1'b1, 2'b00, 1'b0, 32'h18 + 32'(k), 32'h80 + 32'(k), 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h18, 32'd0, 0);
        check("byte_lanes_word", last_rdata, 32'h8382_8180);
        do_req(1'b0, 2'b00, 1'b0, 32'h1B, 32'd0, 0);
        check("lane3_signed", last_rdata, 32'hFFFF_FF83);
        do_req(1'b0, 2'b10, 1'b0, 32'h1A, 32'd0, 0);
`ifdef LSU_ALIGN_CHECK_EN
        check("lw_misalign_err", 32'(last_err), 32'd1);
`else
        check("lw_lane0_word", last_rdata, 32'h8382_8180);
`endif
        do_req(1'b1, 2'b01, 1'b0, 32'h15, 32'hCAFE_1234, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 0);

        repeat (3) @(posedge clk);
        check("pending_responses", 32'(exp_q.size()), 32'd0);
        check("pending_writes", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
